// File: rtl/mem_access_unit_if.sv
// Request, completion and block-memory signals of mem_access_unit bundled as one interface.
// The slave modport is the unit; the master modport is the requester/memory side.
interface mem_access_unit_if;
  logic        start;
  logic        ls;
  logic [31:0] base;
  logic [5:0]  imm;
  logic [3:0]  rd;
  logic [31:0] store_data;
  logic [31:0] mem_dout;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        busy;
  logic        done;
  logic        err;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] load_data;

  modport master (
    output start, ls, base, imm, rd, store_data, mem_dout,
    input  mem_en, mem_we, mem_addr, mem_din, busy, done, err, rf_we, rf_waddr, load_data
  );

  modport slave (
    input  start, ls, base, imm, rd, store_data, mem_dout,
    output mem_en, mem_we, mem_addr, mem_din, busy, done, err, rf_we, rf_waddr, load_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// Single-word load/store unit: latches a request, forms base+offset, range-checks it,
// then drives one block-memory access and reports completion (and load writeback).
module mem_access_unit #(
  parameter int MEM_DEPTH    = 64,
  parameter int READ_LATENCY = 2
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ADDR, ACCESS, WAIT, DONE} state_t;

  state_t      state, next;
  logic        ls_q;
  logic [31:0] base_q;
  logic [5:0]  imm_q;
  logic [3:0]  rd_q;
  logic [31:0] sd_q;
  logic [31:0] addr_q;
  logic        err_q;
  logic [2:0]  cnt;
  logic [31:0] load_q;
  logic [31:0] sum;
  logic        oor;

  assign sum = base_q + {{26{imm_q[5]}}, imm_q};
  assign oor = (sum >= 32'(MEM_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (bus.start) next = ADDR;
      ADDR:    next = oor ? DONE : ACCESS;
      ACCESS:  next = ls_q ? DONE : WAIT;
      WAIT:    if (cnt == 3'd1) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Request fields are frozen at acceptance so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ls_q   <= 1'b0;
      base_q <= '0;
      imm_q  <= '0;
      rd_q   <= '0;
      sd_q   <= '0;
      addr_q <= '0;
      err_q  <= 1'b0;
      cnt    <= '0;
      load_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          ls_q   <= bus.ls;
          base_q <= bus.base;
          imm_q  <= bus.imm;
          rd_q   <= bus.rd;
          sd_q   <= bus.store_data;
        end
        ADDR: begin
          addr_q <= sum;
          err_q  <= oor;
        end
        ACCESS: cnt <= 3'(READ_LATENCY);
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) load_q <= bus.mem_dout;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.mem_en = 1'b0;
    bus.mem_we = '0;
    bus.busy   = (state != IDLE);
    bus.done   = 1'b0;
    bus.err    = 1'b0;
    bus.rf_we  = 1'b0;
    unique case (state)
      ACCESS: begin
        bus.mem_en = 1'b1;
        bus.mem_we = ls_q ? 4'hF : 4'h0;
      end
      WAIT: bus.mem_en = 1'b1;
      DONE: begin
        bus.done  = 1'b1;
        bus.err   = err_q;
        bus.rf_we = !ls_q && !err_q;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_din   = sd_q;
  assign bus.rf_waddr  = rd_q;
  assign bus.load_data = load_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural block memory of fixed read latency.
module tb_mem_access_unit;
  localparam int DEPTH = 64;
  localparam int RL    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem  [DEPTH];
  logic [31:0] pipe [4];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we == 4'hF) mem[bus.mem_addr[5:0]] <= bus.mem_din;
      pipe[0] <= mem[bus.mem_addr[5:0]];
    end
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_dout = pipe[RL-1];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  int          lat, en_cnt, we_cnt, done_cnt, err_cnt, rfwe_cnt;
  logic [3:0]  we_val;
  logic [31:0] we_addr, we_din, d_addr;
  logic [3:0]  d_waddr;
  logic        d_rfwe, d_err;

  task automatic sample();
    if (bus.mem_en) en_cnt++;
    if (bus.mem_we != 4'h0) begin
      we_cnt++;
      we_val  = bus.mem_we;
      we_addr = bus.mem_addr;
      we_din  = bus.mem_din;
    end
    if (bus.err) err_cnt++;
    if (bus.rf_we) rfwe_cnt++;
    if (bus.done) begin
      done_cnt++;
      d_addr  = bus.mem_addr;
      d_waddr = bus.rf_waddr;
      d_rfwe  = bus.rf_we;
      d_err   = bus.err;
    end
  endtask

  // Issues one request; inputs are scrambled after acceptance, optional start poke mid-run.
  task automatic run_req(input logic l, input logic [31:0] b, input logic [5:0] im,
                         input logic [3:0] r, input logic [31:0] sd, input bit poke);
    @(negedge clk);
    bus.ls = l; bus.base = b; bus.imm = im; bus.rd = r; bus.store_data = sd;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.ls = ~l; bus.base = ~b; bus.imm = ~im; bus.rd = ~r; bus.store_data = ~sd;
    lat = 0; en_cnt = 0; we_cnt = 0; done_cnt = 0; err_cnt = 0; rfwe_cnt = 0;
    we_val = '0; we_addr = '0; we_din = '0; d_addr = '0; d_waddr = '0; d_rfwe = 0; d_err = 0;
    sample();
    while (done_cnt == 0 && lat < 30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.start = poke && (lat == 2);
      sample();
    end
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sample();
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) pipe[i] = '0;
    bus.start = 0; bus.ls = 0; bus.base = '0; bus.imm = '0; bus.rd = '0; bus.store_data = '0;

    // Start held high during reset must be ignored.
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy",   {31'b0, bus.busy},   32'd0);
    check("rst_done",   {31'b0, bus.done},   32'd0);
    check("rst_en",     {31'b0, bus.mem_en}, 32'd0);
    check("rst_we",     {28'b0, bus.mem_we}, 32'd0);
    check("rst_addr",   bus.mem_addr,        32'd0);
    check("rst_din",    bus.mem_din,         32'd0);
    check("rst_ld",     bus.load_data,       32'd0);
    check("rst_rfwe",   {31'b0, bus.rf_we},  32'd0);
    check("rst_waddr",  {28'b0, bus.rf_waddr}, 32'd0);
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_req(1'b1, 32'd5, 6'h3D, 4'd2, 32'hDEADBEEF, 0);
    check("st_lat",     lat,                 32'd2);
    check("st_we_cnt",  we_cnt,              32'd1);
    check("st_we_val",  {28'b0, we_val},     32'hF);
    check("st_addr",    we_addr,             32'd2);
    check("st_din",     we_din,              32'hDEADBEEF);
    check("st_en_cnt",  en_cnt,              32'd1);
    check("st_done",    done_cnt,            32'd1);
    check("st_rfwe",    rfwe_cnt,            32'd0);
    check("st_err",     err_cnt,             32'd0);
    check("st_mem",     mem[2],              32'hDEADBEEF);

    run_req(1'b0, 32'd1, 6'd1, 4'd7, 32'h0, 0);
    check("ld_lat",     lat,                 32'd3 + RL - 1);
    check("ld_data",    bus.load_data,       32'hDEADBEEF);
    check("ld_rfwe_d",  {31'b0, d_rfwe},     32'd1);
    check("ld_rfwe_n",  rfwe_cnt,            32'd1);
    check("ld_waddr",   {28'b0, d_waddr},    32'd7);
    check("ld_en_cnt",  en_cnt,              32'd1 + RL);
    check("ld_we_cnt",  we_cnt,              32'd0);

    run_req(1'b0, 32'd0, 6'h3F, 4'd4, 32'h0, 0);
    check("oor_lat",    lat,                 32'd1);
    check("oor_err_d",  {31'b0, d_err},      32'd1);
    check("oor_err_n",  err_cnt,             32'd1);
    check("oor_en",     en_cnt,              32'd0);
    check("oor_rfwe",   rfwe_cnt,            32'd0);
    check("oor_addr",   d_addr,              32'hFFFFFFFF);
    check("oor_ld",     bus.load_data,       32'hDEADBEEF);

    run_req(1'b1, 32'd60, 6'd3, 4'd0, 32'h12345678, 0);
    check("b63_lat",    lat,                 32'd2);
    check("b63_err",    err_cnt,             32'd0);
    check("b63_addr",   we_addr,             32'd63);
    run_req(1'b0, 32'd60, 6'd4, 4'd1, 32'h0, 0);
    check("b64_lat",    lat,                 32'd1);
    check("b64_err",    {31'b0, d_err},      32'd1);
    check("b64_en",     en_cnt,              32'd0);

    run_req(1'b0, 32'd60, 6'd3, 4'd3, 32'h0, 1);
    check("poke_lat",   lat,                 32'd2 + RL);
    check("poke_done",  done_cnt,            32'd1);
    check("poke_ld",    bus.load_data,       32'h12345678);
    check("poke_waddr", {28'b0, d_waddr},    32'd3);
    check("poke_busy",  {31'b0, bus.busy},   32'd0);

    // Reset asserted between edges while the load sits in WAIT.
    @(negedge clk);
    bus.ls = 1'b0; bus.base = 32'd1; bus.imm = 6'd1; bus.rd = 4'd5; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rw_en_pre",  {31'b0, bus.mem_en}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rw_en",      {31'b0, bus.mem_en}, 32'd0);
    check("rw_busy",    {31'b0, bus.busy},   32'd0);
    check("rw_we",      {28'b0, bus.mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    done_cnt = 0; rfwe_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
      if (bus.rf_we) rfwe_cnt++;
    end
    check("rw_done",    done_cnt,            32'd0);
    check("rw_rfwe",    rfwe_cnt,            32'd0);
    check("rw_ld",      bus.load_data,       32'd0);

    run_req(1'b1, 32'd10, 6'd0, 4'd0, 32'hA5A5A5A5, 0);
    check("rec_lat",    lat,                 32'd2);
    check("rec_mem",    mem[10],             32'hA5A5A5A5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 64: number of 32-bit words in the attached block memory.
REQ-002 SHALL have parameter READ_LATENCY, default 2 (legal 1..4): cycles from enabled read address to valid mem_dout.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: request strobe, sampled only in IDLE.
REQ-006 SHALL have port ls, input, 1: 0 = load, 1 = store.
REQ-007 SHALL have port base, input, 32: address register value.
REQ-008 SHALL have port imm, input, 6: signed word offset.
REQ-009 SHALL have port rd, input, 4: load destination register index.
REQ-010 SHALL have port store_data, input, 32: store source register value.
REQ-011 SHALL have port mem_dout, input, 32: block memory read data.
REQ-012 SHALL have port mem_en, output, 1: block memory enable.
REQ-013 SHALL have port mem_we, output, 4: block memory byte write enables.
REQ-014 SHALL have port mem_addr, output, 32: block memory word address.
REQ-015 SHALL have port mem_din, output, 32: block memory write data.
REQ-016 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-017 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-018 SHALL have port err, output, 1: address out of range; valid with done.
REQ-019 SHALL have port rf_we, output, 1: one-cycle register bank write strobe.
REQ-020 SHALL have port rf_waddr, output, 4: register bank write index.
REQ-021 SHALL have port load_data, output, 32: captured load result, held until next capture.

Function
REQ-022 SHALL implement FSM states IDLE, ADDR, ACCESS, WAIT, DONE.
REQ-023 SHALL, in IDLE with start=1 at an edge, latch ls, base, imm, rd and store_data, then enter ADDR; later input changes SHALL have no effect on the request.
REQ-024 SHALL ignore start in every state except IDLE; no request queueing.
REQ-025 SHALL, in ADDR, register mem_addr = base + sign-extended imm, computed modulo 2^32.
REQ-026 SHALL, in ADDR, treat the sum as unsigned; if it is >= MEM_DEPTH, go to DONE with err=1 and never assert mem_en; otherwise go to ACCESS.
REQ-027 SHALL, in ACCESS, drive mem_en=1 for one cycle, with mem_we=4'hF for a store or 4'h0 for a load, and mem_din equal to the latched store_data.
REQ-028 SHALL, after ACCESS, go to DONE for a store or to WAIT for a load.
REQ-029 SHALL, in WAIT, hold mem_en=1 and mem_we=0 for exactly READ_LATENCY cycles using a down-counter.
REQ-030 SHALL capture mem_dout into load_data at the final WAIT edge.
REQ-031 SHALL, in DONE, assert done=1 for one cycle and return to IDLE.
REQ-032 SHALL, in DONE for a successful load, assert rf_we=1 with rf_waddr equal to the latched rd.
REQ-033 SHALL hold rf_we=0 for a store or an error.
REQ-034 SHALL meet these latencies, with start sampled at edge T: done at cycle T+3 for a store, T+3+READ_LATENCY for a load, T+2 for an error.
REQ-035 SHALL hold mem_we=0 outside ACCESS, and mem_en=0 outside ACCESS and WAIT.
REQ-036 SHALL hold err low except in the DONE cycle of an out-of-range request.
REQ-037 SHALL accept a new start in the cycle after DONE, i.e. the first IDLE cycle.

Reset
REQ-038 SHALL, while rst=0, force state IDLE and clear mem_en, mem_we, mem_addr, mem_din, busy, done, err, rf_we, rf_waddr, load_data and the WAIT counter, asynchronously without waiting for clk.
REQ-039 SHALL, on reset mid-operation, drop mem_en and mem_we immediately; the aborted request SHALL produce neither done nor rf_we.
REQ-040 SHALL leave IDLE only on a start sampled at a clock edge after rst has risen.

Verification
REQ-041 SHALL cover a store: base=5, imm=6'h3D (-3), store_data=32'hDEADBEEF -> mem_addr=2 and mem_we=4'hF for one cycle at T+2, done at T+3, rf_we=0.
REQ-042 SHALL cover a load with READ_LATENCY=2 after that store: base=1, imm=1, rd=7 -> load_data=32'hDEADBEEF, with rf_we=1, rf_waddr=7 and done all at T+5.
REQ-043 SHALL cover out of range with MEM_DEPTH=64: base=0, imm=6'h3F (-1) -> sum 32'hFFFFFFFF, done and err at T+2, mem_en never high.
REQ-044 SHALL cover upper boundary: base=60, imm=3 accepted (addr 63); base=60, imm=4 -> err=1.
REQ-045 SHALL cover start pulsed during a busy load -> ignored, exactly one done, load result unchanged.
REQ-046 SHALL cover rst driven low between clock edges during WAIT -> mem_en=0 and busy=0 before the next edge; no done or rf_we follows.
